// File: rtl/mb_seq_pkg.sv
// Shared types and constants for the macroblock pipeline sequencer.
//   state_t          : sequencer FSM states (3-bit encoding)
//   mode_t           : intra prediction mode codes carried on pred_mode/mode
//   MB_X_W / MB_Y_W  : widths of the macroblock position counters
//   WORDS_PER_MB_DEF : default 32-bit words per macroblock (16x16 bytes / 4)
package mb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INQ,
    ST_LOAD,
    ST_PRED,
    ST_RESID,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_VERT,
    MODE_HORZ,
    MODE_DC,
    MODE_PLANE
  } mode_t;

  localparam int unsigned MB_X_W           = 5;
  localparam int unsigned MB_Y_W           = 5;
  localparam int unsigned WORDS_PER_MB_DEF = 64;

endpackage

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock position counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to (0,0)
//   adv        : step one MB right, wrapping to the next row at the frame edge
//   x, y       : current MB position
//   last       : current position is the bottom-right MB
//   lin_idx    : y*W + x, zero-extended to ADDR_W
module mb_raster_counter
  import mb_seq_pkg::*;
#(
  parameter int unsigned W      = 22,
  parameter int unsigned H      = 18,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [MB_X_W-1:0] x,
  output logic [MB_Y_W-1:0] y,
  output logic              last,
  output logic [ADDR_W-1:0] lin_idx
);

  logic [MB_X_W-1:0] x_q, x_d;
  logic [MB_Y_W-1:0] y_q, y_d;
  logic              x_at_edge;

  assign x_at_edge = (x_q == MB_X_W'(W - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_at_edge) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign last    = x_at_edge && (y_q == MB_Y_W'(H - 1));
  assign lin_idx = ADDR_W'(y_q) * ADDR_W'(W) + ADDR_W'(x_q);

endmodule

// File: rtl/mb_pipeline_sequencer.sv
// Per-macroblock scheduler between the memory interface, intra prediction
// and the DCT stage. Walks the frame in raster order; for each MB it clears
// the DCT, publishes the neighbour-inquiry index, requests the MB, waits for
// the prediction decision, then meters WORDS_PER_MB residual words.
//   start/abort           : frame control (abort wins, keeps err)
//   mb_avail/mb_load      : MB request handshake with the memory interface
//   word_valid            : MB word delivered to the intra unit
//   inq_addr/inq_update   : neighbour-inquiry index and its strobe
//   pred_done/pred_mode   : intra decision; mode holds the latched result
//   res_valid/dct_ready   : residual transfer (res_valid & dct_ready)
//   dct_clear             : DCT clear pulse ahead of each MB
//   mb_x/mb_y             : current MB position
//   busy/frame_done/err   : frame status, end pulse, sticky protocol error
module mb_pipeline_sequencer
  import mb_seq_pkg::*;
#(
  parameter int unsigned FRAME_W_MB   = 22,
  parameter int unsigned FRAME_H_MB   = 18,
  parameter int unsigned WORDS_PER_MB = WORDS_PER_MB_DEF,
  parameter int unsigned ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mb_avail,
  output logic              mb_load,
  input  logic              word_valid,
  output logic [ADDR_W-1:0] inq_addr,
  output logic              inq_update,
  input  logic              pred_done,
  input  logic [1:0]        pred_mode,
  output logic [1:0]        mode,
  input  logic              res_valid,
  input  logic              dct_ready,
  output logic              dct_clear,
  output logic [MB_X_W-1:0] mb_x,
  output logic [MB_Y_W-1:0] mb_y,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_MB) + 1;
  localparam logic [CNT_W-1:0] WORDS_FULL = CNT_W'(WORDS_PER_MB);
  localparam logic [CNT_W-1:0] RES_LAST   = CNT_W'(WORDS_PER_MB - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  inq_addr_q, inq_addr_d;
  logic               inq_update_q, inq_update_d;
  logic               dct_clear_q, dct_clear_d;
  logic               mb_load_q, mb_load_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;

  logic               pos_clr, pos_adv, pos_last;
  logic [ADDR_W-1:0]  pos_idx;
  logic               transfer, proto_err;

  mb_raster_counter #(
    .W      (FRAME_W_MB),
    .H      (FRAME_H_MB),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pos_clr),
    .adv     (pos_adv),
    .x       (mb_x),
    .y       (mb_y),
    .last    (pos_last),
    .lin_idx (pos_idx)
  );

  assign transfer  = res_valid & dct_ready;
  assign proto_err = (word_valid && (state_q != ST_PRED)) ||
                     (res_valid  && (state_q != ST_RESID));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    res_cnt_d  = res_cnt_q;
    mode_d     = mode_q;
    inq_addr_d = inq_addr_q;
    busy_d     = busy_q;
    err_d      = err_q | proto_err;
    mb_load_d  = 1'b0;
    pos_clr    = 1'b0;
    pos_adv    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          pos_clr = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        // Index is captured here so it is already stable while inq_update is high.
        inq_addr_d = pos_idx;
        state_d    = ST_INQ;
      end
      ST_INQ: state_d = ST_LOAD;
      ST_LOAD: begin
        if (mb_avail) begin
          mb_load_d  = 1'b1;
          word_cnt_d = '0;
          state_d    = ST_PRED;
        end
      end
      ST_PRED: begin
        if (word_valid && (word_cnt_q != WORDS_FULL)) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        if (pred_done) begin
          mode_d    = pred_mode;
          res_cnt_d = '0;
          state_d   = ST_RESID;
          // A word arriving alongside pred_done still counts toward the MB.
          if (word_cnt_d < WORDS_FULL) begin
            err_d = 1'b1;
          end
        end
      end
      ST_RESID: begin
        if (transfer) begin
          res_cnt_d = res_cnt_q + 1'b1;
          if (res_cnt_q == RES_LAST) begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        // Position is left on the last MB so it still reads back after the frame.
        if (pos_last) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          pos_adv = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      word_cnt_d = '0;
      res_cnt_d  = '0;
      mb_load_d  = 1'b0;
      pos_clr    = 1'b1;
      pos_adv    = 1'b0;
      err_d      = err_q | proto_err;
    end

    dct_clear_d  = (state_d == ST_CLEAR);
    inq_update_d = (state_d == ST_INQ);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      res_cnt_q    <= '0;
      mode_q       <= '0;
      inq_addr_q   <= '0;
      inq_update_q <= 1'b0;
      dct_clear_q  <= 1'b0;
      mb_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      res_cnt_q    <= res_cnt_d;
      mode_q       <= mode_d;
      inq_addr_q   <= inq_addr_d;
      inq_update_q <= inq_update_d;
      dct_clear_q  <= dct_clear_d;
      mb_load_q    <= mb_load_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign mb_load    = mb_load_q;
  assign inq_addr   = inq_addr_q;
  assign inq_update = inq_update_q;
  assign mode       = mode_q;
  assign dct_clear  = dct_clear_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
